// File: rtl/latch_ctrl_pkg.sv
// latch_ctrl_pkg: FSM state encoding, parameter defaults and ENABLE counter width for latch_write_arb
package latch_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ENABLE, HOLD} state_t;
  localparam int DW_DEF = 8;
  localparam int AW_DEF = 3;
  localparam int EN_CYCLES_DEF = 1;
  localparam int CW = 4;
endpackage

// File: rtl/latch_write_arb_if.sv
// latch_write_arb_if: requester A/B req/addr/data/ack plus latch bus lat_D/lat_En and busy; master = requesters, slave = arbiter
interface latch_write_arb_if import latch_ctrl_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) ();
  logic a_req, b_req, a_ack, b_ack, busy;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data, lat_D;
  logic [(1 << AW)-1:0] lat_En;
  modport master(output a_req, a_addr, a_data, b_req, b_addr, b_data, input a_ack, b_ack, lat_D, lat_En, busy);
  modport slave(input a_req, a_addr, a_data, b_req, b_addr, b_data, output a_ack, b_ack, lat_D, lat_En, busy);
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; req/mask bit0=A bit1=B, last=1 means B granted last, grant one-hot
module rr_arb2 (
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       last,
  output logic [1:0] grant
);
  logic [1:0] r;
  assign r = req & ~mask;
  assign grant = &r ? (last ? 2'b01 : 2'b10) : r;
endmodule

// File: rtl/latch_write_arb.sv
// latch_write_arb: arbitrates A/B writes into a latch bank with SETUP/ENABLE/HOLD sequencing; ports clk, rst, bus (slave modport)
module latch_write_arb import latch_ctrl_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int EN_CYCLES = EN_CYCLES_DEF
) (
  input logic clk,
  input logic rst,
  latch_write_arb_if.slave bus
);
  localparam int NR = 1 << AW;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] addr, addr_n;
  logic [DW-1:0] d_n;
  logic [NR-1:0] en_n, oh;
  logic a_ack_n, b_ack_n, busy_n, last, last_n, done;
  logic [1:0] mask, mask_n, grant;
  assign oh = NR'(1) << addr;
  assign done = cnt == '0;
  rr_arb2 u_arb (.req({bus.b_req, bus.a_req}), .mask(mask), .last(last), .grant(grant));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      addr <= '0;
      last <= 1'b1;
      mask <= '0;
      bus.lat_D <= '0;
      bus.lat_En <= '0;
      bus.a_ack <= 1'b0;
      bus.b_ack <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      addr <= addr_n;
      last <= last_n;
      mask <= mask_n;
      bus.lat_D <= d_n;
      bus.lat_En <= en_n;
      bus.a_ack <= a_ack_n;
      bus.b_ack <= b_ack_n;
      bus.busy <= busy_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    addr_n = addr;
    d_n = bus.lat_D;
    en_n = '0;
    a_ack_n = 1'b0;
    b_ack_n = 1'b0;
    busy_n = 1'b1;
    last_n = last;
    mask_n = '0;
    case (state)
      IDLE: begin
        busy_n = |grant;
        state_n = |grant ? SETUP : IDLE;
        last_n = |grant ? grant[1] : last;
        addr_n = |grant ? (grant[1] ? bus.b_addr : bus.a_addr) : addr;
        d_n = |grant ? (grant[1] ? bus.b_data : bus.a_data) : bus.lat_D;
      end
      SETUP: begin
        state_n = ENABLE;
        cnt_n = CW'(EN_CYCLES - 1);
        en_n = oh;
      end
      ENABLE: begin
        state_n = done ? HOLD : ENABLE;
        cnt_n = done ? cnt : cnt - CW'(1);
        en_n = done ? '0 : oh;
        a_ack_n = done && !last;
        b_ack_n = done && last;
      end
      HOLD: begin
        state_n = IDLE;
        busy_n = 1'b0;
        mask_n = last ? 2'b10 : 2'b01;
      end
    endcase
  end
endmodule
